// File: rtl/clock_step_pkg.sv
// Shared types for the clock step controller: FSM state encodings and tick-counter sizing.
// Pure declarations; no logic, latency or backpressure.
package clock_step_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int CNT_W = 15;
  localparam int DIV_W = 4;

  // Terminal count for a 2^sel period, one bit wider so div_sel=15 cannot wrap.
  function automatic logic [CNT_W:0] tick_term(input logic [DIV_W-1:0] sel);
    logic [CNT_W:0] one;
    one = (CNT_W+1)'(1);
    return (one << sel) - one;
  endfunction

endpackage

// File: rtl/clock_step_ctrl_if.sv
// Board-side control bundle of the clock step controller (mode, button, divider, halt, enables).
// No handshake: level/pulse signals only, no backpressure.
interface clock_step_ctrl_if;
  import clock_step_pkg::*;

  logic             run_mode;
  logic             step_btn;
  logic [DIV_W-1:0] div_sel;
  logic             halt;
  logic             tick_o;
  logic             proc_en;
  logic [1:0]       state_o;

  modport master (
    output run_mode, step_btn, div_sel, halt,
    input  tick_o, proc_en, state_o
  );

  modport slave (
    input  run_mode, step_btn, div_sel, halt,
    output tick_o, proc_en, state_o
  );

endinterface

// File: rtl/button_debounce.sv
// Synchronise, debounce and rising-edge detect a raw push-button; pressed_o pulses 2+(2^W-1)+1 cycles after a clean press.
// No backpressure; a button already held when reset is released must be released before it can fire.
module button_debounce #(
  parameter int p_db_width = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pressed_o
);

  logic                  sync_a;
  logic                  sync_b;
  logic [1:0]            sync_ok;
  logic                  stable;
  logic                  armed;
  logic [p_db_width-1:0] db_cnt;
  logic                  take;

  assign take = (sync_b != stable) && (&db_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      sync_ok   <= 2'b00;
      stable    <= 1'b0;
      armed     <= 1'b0;
      db_cnt    <= '0;
      pressed_o <= 1'b0;
    end else begin
      sync_a  <= btn_in;
      sync_b  <= sync_a;
      sync_ok <= {sync_ok[0], 1'b1};

      if (sync_b == stable) begin
        db_cnt <= '0;
      end else if (&db_cnt) begin
        stable <= sync_b;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + p_db_width'(1);
      end

      // Only arm once a genuine released level has made it through the synchroniser.
      if (sync_ok[1] && !sync_b && !stable) begin
        armed <= 1'b1;
      end

      pressed_o <= take && sync_b && armed;
    end
  end

endmodule

// File: rtl/clock_step_ctrl.sv
// Processor clock-enable generator: free-run at 2^div_sel rate, pause, single-step or halt.
// tick_o/proc_en are combinational from the counter/state in the same cycle; no backpressure.
module clock_step_ctrl
  import clock_step_pkg::*;
#(
  parameter int p_db_width = 16
) (
  input logic               clk,
  input logic               rst,
  clock_step_ctrl_if.slave  bus
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   term;
  logic             tick;
  logic             step_req;
  logic             proc_en_c;
  state_t           state;
  state_t           state_nxt;

  // >= compare so a divider decrease mid-period wraps on the next cycle.
  assign term = tick_term(bus.div_sel);
  assign tick = ({1'b0, cnt} >= term);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  button_debounce #(
    .p_db_width (p_db_width)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (bus.step_btn),
    .pressed_o (step_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_PAUSE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    proc_en_c = 1'b0;
    case (state)
      ST_PAUSE: begin
        if (bus.run_mode) begin
          state_nxt = ST_RUN;
        end else if (step_req) begin
          state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        proc_en_c = tick & ~bus.halt;
        if (bus.halt) begin
          state_nxt = ST_HALT;
        end else if (!bus.run_mode) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_STEP: begin
        // run_mode is deliberately ignored here so a pending step always completes.
        if (bus.halt) begin
          state_nxt = ST_HALT;
        end else if (tick) begin
          proc_en_c = 1'b1;
          state_nxt = ST_PAUSE;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_PAUSE;
      end
    endcase
  end

  assign bus.tick_o  = tick & ~rst;
  assign bus.proc_en = proc_en_c & ~rst;
  assign bus.state_o = state;

endmodule
